mem_arbiter: RTL and testbench

Shared-memory arbiter and line-fill sequencer for the cached CPU. It sits between the instruction-cache and data-cache miss handlers and the single unified multicycle main memory. It grants the memory to one requester at a time and, for a fill, issues WORDS consecutive word reads. It then counts the in-order returns, forwards each word with its index, and signals completion; single-word data writes are also sequenced.

---
 rtl/mem_arbiter.sv | 145 ++++++++++++++
 tb/tb_mem_arbiter.sv | 458 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Shared-memory arbiter for the I- and D-cache miss handlers. It grants the single
// multicycle memory to one requester at a time, sequences line fills and single-word writes.
module mem_arbiter #(
    parameter  int MEM_LAT = 4,
    parameter  int WORDS   = 8,
    localparam int IDX_W   = $clog2(WORDS)
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             i_req,
    input  logic [15:0]      i_addr,
    output logic             i_grant,
    output logic             i_data_valid,
    output logic             i_done,

    input  logic             d_req,
    input  logic             d_wr,
    input  logic [15:0]      d_addr,
    input  logic [15:0]      d_wdata,
    output logic             d_grant,
    output logic             d_data_valid,
    output logic             d_done,

    output logic [15:0]      rdata,
    output logic [IDX_W-1:0] word_idx,

    output logic             mem_en,
    output logic             mem_wr,
    output logic [15:0]      mem_addr,
    output logic [15:0]      mem_wdata,
    input  logic [15:0]      mem_rdata,
    input  logic             mem_rvalid
);

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_WRITE} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_I, OWN_D} owner_t;

    localparam logic [15:0]      BASE_MASK = ~16'(2 * WORDS - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(WORDS - 1);

    state_t           state;
    owner_t           owner;
    logic             last_d;
    logic [15:0]      base;
    logic [IDX_W-1:0] issue_cnt;
    logic [IDX_W-1:0] ret_cnt;
    logic             issuing;

    logic             pick_d;
    logic             pick_i;
    logic             rvalid_fill;
    logic             ret_last;

    // On a tie the side not served last wins; last_d resets low so D wins the first tie.
    assign pick_d      = d_req && (!i_req || !last_d);
    assign pick_i      = i_req && !pick_d;

    assign rvalid_fill = (state == S_FILL) && mem_rvalid;
    assign ret_last    = rvalid_fill && (ret_cnt == LAST_IDX);

    assign i_grant      = (owner == OWN_I);
    assign d_grant      = (owner == OWN_D);
    assign i_data_valid = rvalid_fill && (owner == OWN_I);
    assign d_data_valid = rvalid_fill && (owner == OWN_D);
    assign i_done       = ret_last && (owner == OWN_I);
    assign d_done       = (ret_last && (owner == OWN_D)) || (state == S_WRITE);
    assign rdata        = rvalid_fill ? mem_rdata : 16'h0000;
    assign word_idx     = rvalid_fill ? ret_cnt : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            owner     <= OWN_NONE;
            last_d    <= 1'b0;
            base      <= 16'h0000;
            issue_cnt <= '0;
            ret_cnt   <= '0;
            issuing   <= 1'b0;
            mem_en    <= 1'b0;
            mem_wr    <= 1'b0;
            mem_addr  <= 16'h0000;
            mem_wdata <= 16'h0000;
        end else begin
            // NOTE: non-blocking defaults; the memory strobes are low unless this edge issues.
            mem_en    <= 1'b0;
            mem_wr    <= 1'b0;
            mem_addr  <= 16'h0000;
            mem_wdata <= 16'h0000;

            unique case (state)
                S_IDLE: begin
                    ret_cnt <= '0;
                    if (pick_d && d_wr) begin
                        state     <= S_WRITE;
                        owner     <= OWN_D;
                        last_d    <= 1'b1;
                        mem_en    <= 1'b1;
                        mem_wr    <= 1'b1;
                        mem_addr  <= d_addr;
                        mem_wdata <= d_wdata;
                    end else if (pick_d || pick_i) begin
                        state     <= S_FILL;
                        owner     <= pick_d ? OWN_D : OWN_I;
                        last_d    <= pick_d;
                        base      <= (pick_d ? d_addr : i_addr) & BASE_MASK;
                        mem_en    <= 1'b1;
                        mem_addr  <= (pick_d ? d_addr : i_addr) & BASE_MASK;
                        issue_cnt <= IDX_W'(1);
                        issuing   <= 1'b1;
                    end
                end

                S_FILL: begin
                    if (issuing) begin
                        mem_en    <= 1'b1;
                        mem_addr  <= base + 16'({issue_cnt, 1'b0});
                        issue_cnt <= issue_cnt + IDX_W'(1);
                        if (issue_cnt == LAST_IDX) begin
                            issuing <= 1'b0;
                        end
                    end
                    if (rvalid_fill) begin
                        ret_cnt <= ret_cnt + IDX_W'(1);
                        if (ret_cnt == LAST_IDX) begin
                            state <= S_IDLE;
                            owner <= OWN_NONE;
                        end
                    end
                end

                S_WRITE: begin
                    state <= S_IDLE;
                    owner <= OWN_NONE;
                end

                default: begin
                    state <= S_IDLE;
                    owner <= OWN_NONE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: a latency-accurate memory model and a negedge monitor.
// Scenario tasks compare the logged bus and return traffic with the arbitration and fill rules.
module tb_mem_arbiter;

    localparam int MEM_LAT = 4;
    localparam int WORDS   = 8;
    localparam int IDX_W   = $clog2(WORDS);
    localparam int LIMIT   = 200;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             i_req = 1'b0, d_req = 1'b0, d_wr = 1'b0;
    logic [15:0]      i_addr = 16'h0, d_addr = 16'h0, d_wdata = 16'h0;
    logic             i_grant, i_data_valid, i_done;
    logic             d_grant, d_data_valid, d_done;
    logic [15:0]      rdata;
    logic [IDX_W-1:0] word_idx;
    logic             mem_en, mem_wr;
    logic [15:0]      mem_addr, mem_wdata;
    logic [15:0]      mem_rdata = 16'h0;
    logic             mem_rvalid = 1'b0;

    mem_arbiter #(.MEM_LAT(MEM_LAT), .WORDS(WORDS)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_grant(i_grant),
        .i_data_valid(i_data_valid), .i_done(i_done),
        .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_grant(d_grant), .d_data_valid(d_data_valid), .d_done(d_done),
        .rdata(rdata), .word_idx(word_idx),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid)
    );

    always #5 clk = ~clk;

    logic [56+IDX_W-1:0] all_out;
    assign all_out = {i_grant, i_data_valid, i_done, d_grant, d_data_valid, d_done,
                      rdata, word_idx, mem_en, mem_wr, mem_addr, mem_wdata};

    typedef struct { int cyc; logic wr; logic [15:0] addr; logic [15:0] wdata; } issue_t;
    typedef struct { int cyc; logic side_d; int idx; logic [15:0] data; logic done; } ret_t;
    typedef struct { int cyc; logic side_d; } evt_t;
    typedef struct { int due; logic [15:0] data; } pend_t;

    issue_t      issue_q[$];
    ret_t        ret_q[$];
    evt_t        start_q[$];
    evt_t        done_q[$];
    int          gi_q[$];
    int          gd_q[$];
    pend_t       pend_q[$];
    logic [15:0] mem_model [0:32767];

    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   quiet_bad = 0;
    int   overlap = 0;
    logic prev_i = 1'b0, prev_d = 1'b0;

    // Memory: a read issued in cycle c returns its word during cycle c+MEM_LAT.
    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        mem_rvalid = 1'b0;
        mem_rdata  = 16'h0;
        if (pend_q.size() > 0 && pend_q[0].due == cyc) begin
            mem_rvalid = 1'b1;
            mem_rdata  = pend_q[0].data;
            void'(pend_q.pop_front());
        end
        if (mem_en && !mem_wr) pend_q.push_back(pend_t'{cyc + MEM_LAT, mem_model[mem_addr[15:1]]});
        if (mem_en && mem_wr) mem_model[mem_addr[15:1]] = mem_wdata;
    end

    always @(negedge clk) begin
        if (mem_en) issue_q.push_back(issue_t'{cyc, mem_wr, mem_addr, mem_wdata});
        else if (mem_wr || mem_addr != 16'h0 || mem_wdata != 16'h0) quiet_bad++;
        if (i_data_valid) ret_q.push_back(ret_t'{cyc, 1'b0, int'(word_idx), rdata, i_done});
        if (d_data_valid) ret_q.push_back(ret_t'{cyc, 1'b1, int'(word_idx), rdata, d_done});
        if ((i_data_valid && d_data_valid) || (i_grant && d_grant)) overlap++;
        if (i_grant) gi_q.push_back(cyc);
        if (d_grant) gd_q.push_back(cyc);
        if (i_grant && !prev_i) start_q.push_back(evt_t'{cyc, 1'b0});
        if (d_grant && !prev_d) start_q.push_back(evt_t'{cyc, 1'b1});
        if (i_done) done_q.push_back(evt_t'{cyc, 1'b0});
        if (d_done) done_q.push_back(evt_t'{cyc, 1'b1});
        prev_i = i_grant;
        prev_d = d_grant;
    end

    function automatic void clear_logs();
        issue_q.delete(); ret_q.delete(); start_q.delete(); done_q.delete();
        gi_q.delete(); gd_q.delete();
    endfunction

    // Requesters enter at posedge+2, hold req until done, drop it in the following IDLE cycle.
    task automatic i_requester(input logic [15:0] a, input logic drop);
        int n;
        n = 0;
        i_addr = a;
        i_req = 1'b1;
        do begin
            @(negedge clk);
            n++;
            if (i_grant) begin
                i_addr = 16'($urandom);
                if (drop) i_req = 1'b0;
            end
        end while (!i_done && n < LIMIT);
        checks++;
        if (!i_done) begin
            failures++;
            $display("FAIL i_done_timeout waited=%0d cycles, required done within %0d", n, LIMIT);
        end
        @(posedge clk); #2;
        i_req = 1'b0;
    endtask

    task automatic d_requester(input logic wr, input logic [15:0] a, input logic [15:0] wd,
                               input logic drop);
        int n;
        n = 0;
        d_wr = wr;
        d_addr = a;
        d_wdata = wd;
        d_req = 1'b1;
        do begin
            @(negedge clk);
            n++;
            if (d_grant) begin
                d_addr = 16'($urandom);
                d_wdata = 16'($urandom);
                if (drop) d_req = 1'b0;
            end
        end while (!d_done && n < LIMIT);
        checks++;
        if (!d_done) begin
            failures++;
            $display("FAIL d_done_timeout waited=%0d cycles, required done within %0d", n, LIMIT);
        end
        @(posedge clk); #2;
        d_req = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        i_req = 1'b1;
        d_req = 1'b1;
        d_wr = 1'($urandom_range(0, 1));
        i_addr = 16'($urandom);
        d_addr = 16'($urandom);
        d_wdata = 16'($urandom);
        repeat (3) @(negedge clk);
        checks++;
        if (all_out !== '0) begin
            failures++;
            $display("FAIL reset_hold outputs=%h required=0", all_out);
        end
        i_req = 1'b0;
        d_req = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_tie_after_reset();
        int t0, errs, k;
        logic [15:0] ai, ad, b;
        logic sd;
        @(posedge clk); #2;
        clear_logs();
        ai = 16'($urandom);
        ad = 16'($urandom);
        t0 = cyc;
        fork
            i_requester(ai, 1'b0);
            d_requester(1'b0, ad, 16'h0, 1'b0);
        join
        checks++;
        if (start_q.size() != 2 || start_q[0].side_d !== 1'b1 || start_q[1].side_d !== 1'b0
            || start_q[0].cyc != t0 + 1) begin
            failures++;
            $display("FAIL tie_order grants=%0d first_side_d=%b first_cyc=%0d, required D first at %0d",
                     start_q.size(), start_q.size() > 0 ? start_q[0].side_d : 1'bx,
                     start_q.size() > 0 ? start_q[0].cyc : -1, t0 + 1);
        end
        checks++;
        if (done_q.size() != 2 || start_q.size() != 2 || start_q[1].cyc != done_q[0].cyc + 2) begin
            failures++;
            $display("FAIL tie_second_grant i_grant_cyc=%0d d_done_cyc=%0d, required d_done+2",
                     start_q.size() > 1 ? start_q[1].cyc : -1, done_q.size() > 0 ? done_q[0].cyc : -1);
        end
        errs = 0;
        for (int j = 0; j < ret_q.size(); j++) begin
            sd = (j < WORDS);
            k = j % WORDS;
            b = (sd ? ad : ai) & ~16'(2 * WORDS - 1);
            if (ret_q[j].side_d !== sd || ret_q[j].idx != k
                || ret_q[j].data !== mem_model[(b >> 1) + k]) errs++;
        end
        checks++;
        if (ret_q.size() != 2 * WORDS || errs != 0 || overlap != 0) begin
            failures++;
            $display("FAIL tie_returns count=%0d bad=%0d overlap=%0d, required %0d/0/0",
                     ret_q.size(), errs, overlap, 2 * WORDS);
        end
    endtask

    task automatic test_fill(input logic side_d, input logic [15:0] a, input logic drop);
        logic [15:0] base, ea;
        logic [15:0] exp_w [WORDS];
        int g, own_n, own_first, own_last, other_n;
        @(posedge clk); #2;
        clear_logs();
        base = a & ~16'(2 * WORDS - 1);
        for (int k = 0; k < WORDS; k++) exp_w[k] = mem_model[(base >> 1) + k];
        g = cyc + 1;
        if (side_d) d_requester(1'b0, a, 16'($urandom), drop);
        else        i_requester(a, drop);
        own_n     = side_d ? gd_q.size() : gi_q.size();
        own_first = own_n == 0 ? -1 : (side_d ? gd_q[0] : gi_q[0]);
        own_last  = own_n == 0 ? -1 : (side_d ? gd_q[own_n-1] : gi_q[own_n-1]);
        other_n   = side_d ? gi_q.size() : gd_q.size();
        checks++;
        if (own_n != MEM_LAT + WORDS || own_first != g || own_last != g + MEM_LAT + WORDS - 1
            || other_n != 0) begin
            failures++;
            $display("FAIL fill_grant side_d=%b cycles=%0d first=%0d last=%0d other=%0d, required %0d from %0d",
                     side_d, own_n, own_first, own_last, other_n, MEM_LAT + WORDS, g);
        end
        checks++;
        if (issue_q.size() != WORDS) begin
            failures++;
            $display("FAIL fill_issue_count got=%0d required=%0d", issue_q.size(), WORDS);
        end
        for (int k = 0; k < issue_q.size() && k < WORDS; k++) begin
            ea = base + 16'(2 * k);
            checks++;
            if (issue_q[k].addr !== ea || issue_q[k].wr !== 1'b0 || issue_q[k].cyc != g + k) begin
                failures++;
                $display("FAIL fill_issue k=%0d addr=%h wr=%b cyc=%0d, required addr=%h wr=0 cyc=%0d",
                         k, issue_q[k].addr, issue_q[k].wr, issue_q[k].cyc, ea, g + k);
            end
        end
        checks++;
        if (ret_q.size() != WORDS) begin
            failures++;
            $display("FAIL fill_return_count got=%0d required=%0d", ret_q.size(), WORDS);
        end
        for (int k = 0; k < ret_q.size() && k < WORDS; k++) begin
            checks++;
            if (ret_q[k].side_d !== side_d || ret_q[k].idx != k || ret_q[k].data !== exp_w[k]
                || ret_q[k].cyc != g + MEM_LAT + k || ret_q[k].done !== (k == WORDS - 1)) begin
                failures++;
                $display("FAIL fill_return k=%0d side_d=%b idx=%0d data=%h cyc=%0d done=%b, required %b/%0d/%h/%0d/%b",
                         k, ret_q[k].side_d, ret_q[k].idx, ret_q[k].data, ret_q[k].cyc, ret_q[k].done,
                         side_d, k, exp_w[k], g + MEM_LAT + k, k == WORDS - 1);
            end
        end
    endtask

    task automatic test_d_write();
        int w, n, nd;
        @(posedge clk); #2;
        clear_logs();
        w = -1;
        fork
            d_requester(1'b1, 16'h0041, 16'hBEEF, 1'b0);
            begin
                n = 0;
                do begin @(negedge clk); n++; end while (!d_done && n < LIMIT);
                w = cyc;
                @(posedge clk); #2;
                i_requester(16'h2000, 1'b0);
            end
        join
        checks++;
        if (issue_q.size() < 1 || issue_q[0].cyc != w || issue_q[0].wr !== 1'b1
            || issue_q[0].addr !== 16'h0041 || issue_q[0].wdata !== 16'hBEEF) begin
            failures++;
            $display("FAIL write_issue cyc=%0d wr=%b addr=%h wdata=%h, required cyc=%0d 1/0041/beef",
                     issue_q.size() > 0 ? issue_q[0].cyc : -1, issue_q.size() > 0 ? issue_q[0].wr : 1'bx,
                     issue_q.size() > 0 ? issue_q[0].addr : 16'hx, issue_q.size() > 0 ? issue_q[0].wdata : 16'hx, w);
        end
        nd = 0;
        foreach (ret_q[j]) if (ret_q[j].side_d) nd++;
        checks++;
        if (gd_q.size() != 1 || gd_q[0] != w || done_q.size() < 1 || done_q[0].side_d !== 1'b1
            || done_q[0].cyc != w || nd != 0) begin
            failures++;
            $display("FAIL write_single_cycle d_grant_cycles=%0d d_data_valid=%0d, required 1 grant at %0d and 0 valid",
                     gd_q.size(), nd, w);
        end
        checks++;
        if (start_q.size() != 2 || start_q[1].side_d !== 1'b0 || start_q[1].cyc != w + 2) begin
            failures++;
            $display("FAIL write_next_grant i_grant_cyc=%0d, required %0d",
                     start_q.size() > 1 ? start_q[1].cyc : -1, w + 2);
        end
        @(posedge clk); #2;
        clear_logs();
        d_requester(1'b0, 16'h004E, 16'h0, 1'b0);
        checks++;
        if (ret_q.size() < 1 || ret_q[0].data !== 16'hBEEF) begin
            failures++;
            $display("FAIL write_readback word0=%h required=beef", ret_q.size() > 0 ? ret_q[0].data : 16'hx);
        end
    endtask

    task automatic test_fairness();
        logic [15:0] w0, w1;
        int n, idone, nw, bad;
        @(posedge clk); #2;
        clear_logs();
        w0 = 16'($urandom);
        w1 = 16'($urandom);
        d_wr = 1'b1;
        d_addr = 16'h0100;
        d_wdata = w0;
        d_req = 1'b1;
        fork
            begin
                for (int t = 0; t < 2; t++) begin
                    n = 0;
                    do begin @(negedge clk); n++; end while (!d_done && n < LIMIT);
                    @(posedge clk); #2;
                    d_addr = 16'h0102;
                    d_wdata = w1;
                end
                d_req = 1'b0;
            end
            begin
                @(posedge clk); #2;
                i_requester(16'h3456, 1'b0);
            end
        join
        idone = -1;
        foreach (done_q[j]) if (!done_q[j].side_d) idone = done_q[j].cyc;
        checks++;
        if (start_q.size() != 3 || start_q[0].side_d !== 1'b1 || start_q[1].side_d !== 1'b0
            || start_q[2].side_d !== 1'b1) begin
            failures++;
            $display("FAIL fair_order grants=%0d, required D,I,D", start_q.size());
        end
        checks++;
        if (start_q.size() != 3 || start_q[1].cyc != start_q[0].cyc + 2 || start_q[2].cyc != idone + 2) begin
            failures++;
            $display("FAIL fair_timing i_start=%0d d2_start=%0d i_done=%0d, required d1+2 and i_done+2",
                     start_q.size() > 1 ? start_q[1].cyc : -1, start_q.size() > 2 ? start_q[2].cyc : -1, idone);
        end
        nw = 0;
        bad = 0;
        foreach (issue_q[j]) begin
            if (issue_q[j].wr) begin
                if (nw == 0 && (issue_q[j].addr !== 16'h0100 || issue_q[j].wdata !== w0)) bad++;
                if (nw == 1 && (issue_q[j].addr !== 16'h0102 || issue_q[j].wdata !== w1)) bad++;
                nw++;
            end
        end
        checks++;
        if (nw != 2 || bad != 0) begin
            failures++;
            $display("FAIL fair_writes count=%0d bad=%0d, required 2/0", nw, bad);
        end
    endtask

    task automatic test_reset_mid_fill();
        int n, seen, issued, strays;
        @(posedge clk); #2;
        clear_logs();
        i_addr = 16'($urandom);
        i_req = 1'b1;
        n = 0;
        seen = 0;
        while (seen < 3 && n < LIMIT) begin
            @(negedge clk);
            n++;
            if (i_data_valid) seen++;
        end
        #2;
        checks++;
        if (seen != 3 || i_grant !== 1'b1) begin
            failures++;
            $display("FAIL midfill_setup returns=%0d i_grant=%b, required 3 and 1", seen, i_grant);
        end
        rst_n = 1'b0;
        i_req = 1'b0;
        #1;
        checks++;
        if (all_out !== '0) begin
            failures++;
            $display("FAIL async_reset outputs=%h required=0 before any edge", all_out);
        end
        issued = issue_q.size();
        clear_logs();
        strays = 0;
        for (int j = 0; j < 12; j++) begin
            @(negedge clk);
            if (mem_rvalid) strays++;
            if (j == 1) rst_n = 1'b1;
        end
        checks++;
        if (strays != issued - 3 || ret_q.size() != 0 || start_q.size() != 0) begin
            failures++;
            $display("FAIL stray_returns strays=%0d data_valid=%0d grants=%0d, required %0d/0/0",
                     strays, ret_q.size(), start_q.size(), issued - 3);
        end
    endtask

    task automatic test_random();
        logic [15:0] a, wd;
        logic s;
        int sel, k;
        for (int it = 0; it < 8; it++) begin
            sel = $urandom_range(0, 2);
            a = 16'($urandom);
            if (sel == 2) begin
                wd = 16'($urandom);
                s = 1'($urandom_range(0, 1));
                @(posedge clk); #2;
                d_requester(1'b1, a, wd, 1'b0);
                test_fill(s, a, 1'b0);
                k = (a >> 1) & (WORDS - 1);
                checks++;
                if (ret_q.size() != WORDS || ret_q[k].data !== wd) begin
                    failures++;
                    $display("FAIL write_then_fill addr=%h word=%h required=%h",
                             a, ret_q.size() > k ? ret_q[k].data : 16'hx, wd);
                end
            end else begin
                test_fill(sel[0], a, 1'($urandom_range(0, 1)));
            end
        end
    endtask

    task automatic test_bus_quiet();
        checks++;
        if (quiet_bad != 0 || overlap != 0) begin
            failures++;
            $display("FAIL bus_quiet idle_nonzero=%0d overlaps=%0d, required 0/0", quiet_bad, overlap);
        end
    endtask

    initial begin
        for (int i = 0; i < 32768; i++) mem_model[i] = 16'($urandom);
        test_reset();
        test_tie_after_reset();
        test_fill(1'b0, 16'h1236, 1'b0);
        test_d_write();
        test_fairness();
        test_reset_mid_fill();
        test_fill(1'b0, 16'h0010, 1'b0);
        test_random();
        test_bus_quiet();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
